// File: rtl/im_arb_pkg.sv
// Shared types and defaults for the instruction-SRAM port arbiter.
package im_arb_pkg;

    localparam int unsigned MAX_WAIT_DEFAULT = 4;
    localparam int unsigned AW_DEFAULT       = 16;
    localparam int unsigned DW_DEFAULT       = 32;
    localparam int unsigned STRB_W           = 4;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [AW_DEFAULT-1:0] pc;
        logic [DW_DEFAULT-1:0] data;
    } fetch_rsp_t;

endpackage

// File: rtl/im_port_arbiter_if.sv
// Fetch, aux and SRAM-side signals of the IM port arbiter.
interface im_port_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
) ();
    import im_arb_pkg::*;

    logic              fetch_req_valid;
    logic [AW-1:0]     fetch_req_addr;
    logic              fetch_req_ready;
    logic              fetch_rsp_valid;
    logic [AW-1:0]     fetch_rsp_pc;
    logic [DW-1:0]     fetch_rsp_data;
    logic              fetch_rsp_ready;
    logic              flush;

    logic              aux_req_valid;
    logic              aux_req_we;
    logic [AW-1:0]     aux_req_addr;
    logic [DW-1:0]     aux_req_wdata;
    logic [STRB_W-1:0] aux_req_wstrb;
    logic              aux_req_lock;
    logic              aux_req_ready;
    logic              aux_rsp_valid;
    logic [DW-1:0]     aux_rsp_data;

    logic              im_en;
    logic              im_we;
    logic [AW-1:0]     im_addr;
    logic [DW-1:0]     im_wdata;
    logic [STRB_W-1:0] im_wstrb;
    logic [DW-1:0]     im_rdata;

    modport slave (
        input  fetch_req_valid, fetch_req_addr, fetch_rsp_ready, flush,
        input  aux_req_valid, aux_req_we, aux_req_addr, aux_req_wdata, aux_req_wstrb, aux_req_lock,
        input  im_rdata,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_pc, fetch_rsp_data,
        output aux_req_ready, aux_rsp_valid, aux_rsp_data,
        output im_en, im_we, im_addr, im_wdata, im_wstrb
    );

    modport master (
        output fetch_req_valid, fetch_req_addr, fetch_rsp_ready, flush,
        output aux_req_valid, aux_req_we, aux_req_addr, aux_req_wdata, aux_req_wstrb, aux_req_lock,
        output im_rdata,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_pc, fetch_rsp_data,
        input  aux_req_ready, aux_rsp_valid, aux_rsp_data,
        input  im_en, im_we, im_addr, im_wdata, im_wstrb
    );

endinterface

// File: rtl/im_fetch_rsp_fifo.sv
// Two-entry fetch response FIFO; an incoming word bypasses straight to the
// output when the FIFO is empty.
module im_fetch_rsp_fifo
    import im_arb_pkg::*;
#(
    parameter type entry_t = fetch_rsp_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    input  entry_t     in_data,
    output logic       out_valid,
    output entry_t     out_data,
    input  logic       out_ready,
    output logic [1:0] count
);

    entry_t     mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic       empty;
    logic       push;
    logic       pop_mem;

    // A bypassed word consumed in the same cycle never touches storage.
    always_comb begin
        empty     = (count == 2'd0);
        out_valid = !clear && (!empty || in_valid);
        out_data  = empty ? in_data : mem[rd_ptr];
        push      = in_valid && !clear && !(empty && out_ready);
        pop_mem   = out_valid && out_ready && !empty;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= !wr_ptr;
            end
            if (pop_mem) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop_mem);
        end
    end

endmodule

// File: rtl/im_port_arbiter.sv
// Shares the single-port instruction SRAM between the fetch stage and an
// auxiliary read/write master with starvation guard and locked bursts.
module im_port_arbiter
    import im_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int unsigned AW       = AW_DEFAULT,
    parameter int unsigned DW       = DW_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    im_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned OCC_W = 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } rsp_entry_t;

    arb_state_e       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             fetch_inflight;
    logic [AW-1:0]    inflight_pc;
    logic             aux_inflight;

    rsp_entry_t       fifo_in;
    rsp_entry_t       fifo_out;
    logic             fifo_out_valid;
    logic [1:0]       fifo_count;

    logic             live;
    logic             fetch_pop;
    logic [OCC_W-1:0] occ;
    logic             credit_ok;
    logic             fetch_can;
    logic             aux_win;
    logic             aux_gnt;
    logic             fetch_gnt;

    // Flush and reset both drop every fetch response still owed to decode.
    im_fetch_rsp_fifo #(.entry_t(rsp_entry_t)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush || rst),
        .in_valid  (fetch_inflight),
        .in_data   (fifo_in),
        .out_valid (fifo_out_valid),
        .out_data  (fifo_out),
        .out_ready (bus.fetch_rsp_ready),
        .count     (fifo_count)
    );

    // Same-cycle grant; a flush zeroes the occupancy seen by the credit check.
    always_comb begin
        fifo_in   = '{pc: inflight_pc, data: bus.im_rdata};
        live      = !rst;
        fetch_pop = fifo_out_valid && bus.fetch_rsp_ready;
        occ       = OCC_W'(fetch_inflight) + fifo_count;
        credit_ok = bus.flush || ((occ - OCC_W'(fetch_pop)) <= OCC_W'(1));
        fetch_can = live && (state == ARB) && bus.fetch_req_valid && credit_ok;
        aux_win   = bus.aux_req_valid && (!fetch_can || (starve_cnt == CNT_W'(MAX_WAIT)));
        aux_gnt   = live && aux_win;
        fetch_gnt = fetch_can && !aux_win;
    end

    assign bus.fetch_req_ready = fetch_gnt;
    assign bus.aux_req_ready   = aux_gnt;
    assign bus.im_en           = fetch_gnt || aux_gnt;
    assign bus.im_we           = aux_gnt && bus.aux_req_we;
    assign bus.im_addr         = fetch_gnt ? bus.fetch_req_addr :
                                 aux_gnt   ? bus.aux_req_addr   : '0;
    assign bus.im_wdata        = bus.im_we ? bus.aux_req_wdata : '0;
    assign bus.im_wstrb        = bus.im_we ? bus.aux_req_wstrb : '0;

    assign bus.fetch_rsp_valid = fifo_out_valid;
    assign bus.fetch_rsp_pc    = fifo_out_valid ? fifo_out.pc   : '0;
    assign bus.fetch_rsp_data  = fifo_out_valid ? fifo_out.data : '0;
    assign bus.aux_rsp_valid   = live && aux_inflight;
    assign bus.aux_rsp_data    = bus.aux_rsp_valid ? bus.im_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB;
            starve_cnt     <= '0;
            fetch_inflight <= 1'b0;
            inflight_pc    <= '0;
            aux_inflight   <= 1'b0;
        end else begin
            fetch_inflight <= fetch_gnt;
            if (fetch_gnt) begin
                inflight_pc <= bus.fetch_req_addr;
            end
            aux_inflight <= aux_gnt && !bus.aux_req_we;

            if (aux_gnt || !bus.aux_req_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(MAX_WAIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            // The cycle that releases the lock is itself still a LOCK cycle.
            if (state == ARB) begin
                if (aux_gnt && bus.aux_req_lock) begin
                    state <= LOCK;
                end
            end else if (!bus.aux_req_valid || !bus.aux_req_lock) begin
                state <= ARB;
            end
        end
    end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter with a one-cycle-latency SRAM model.
module tb_im_port_arbiter;
    import im_arb_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    im_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    im_port_arbiter #(.MAX_WAIT(4), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Read data is a recognisable function of the address.
    always @(posedge clk) begin
        if (bus.im_en && !bus.im_we) bus.im_rdata <= 32'hC0DE_0000 | 32'(bus.im_addr);
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [15:0] pc);
        chk_b({tag, "_valid"}, bus.fetch_rsp_valid, 1'b1);
        chk_w({tag, "_pc"}, 32'(bus.fetch_rsp_pc), 32'(pc));
        chk_w({tag, "_data"}, bus.fetch_rsp_data, 32'hC0DE_0000 | 32'(pc));
    endtask

    task automatic set_fetch(input logic v, input logic [15:0] a);
        bus.fetch_req_valid = v;
        bus.fetch_req_addr  = a;
    endtask

    task automatic set_aux(input logic v, input logic we, input logic [15:0] a,
                           input logic [31:0] d, input logic lk);
        bus.aux_req_valid = v;
        bus.aux_req_we    = we;
        bus.aux_req_addr  = a;
        bus.aux_req_wdata = d;
        bus.aux_req_wstrb = 4'hF;
        bus.aux_req_lock  = lk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        // Reset with both requesters active: nothing may be granted.
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.fetch_rsp_ready = 1'b1;
        set_fetch(1'b1, 16'h0100);
        set_aux(1'b1, 1'b0, 16'h0200, 32'h0, 1'b0);
        step(); step(); settle();
        chk_b("rst_fetch_ready", bus.fetch_req_ready, 1'b0);
        chk_b("rst_aux_ready", bus.aux_req_ready, 1'b0);
        chk_b("rst_im_en", bus.im_en, 1'b0);
        chk_w("rst_im_addr", 32'(bus.im_addr), 32'h0);
        chk_b("rst_rsp_valid", bus.fetch_rsp_valid, 1'b0);
        chk_b("rst_aux_rsp", bus.aux_rsp_valid, 1'b0);

        step(); rst = 1'b0; set_fetch(1'b0, 16'h0); set_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
        settle();
        chk_b("idle_im_en", bus.im_en, 1'b0);
        chk_b("idle_rsp_valid", bus.fetch_rsp_valid, 1'b0);
        chk_b("idle_state", dut.state == ARB, 1'b1);
        chk_w("idle_starve", 32'(dut.starve_cnt), 32'h0);

        // Fetch streaming at one grant per cycle.
        step(); set_fetch(1'b1, 16'h0000); settle();
        chk_b("str0_ready", bus.fetch_req_ready, 1'b1);
        chk_w("str0_addr", 32'(bus.im_addr), 32'h0);
        chk_b("str0_rsp", bus.fetch_rsp_valid, 1'b0);
        step(); set_fetch(1'b1, 16'h0004); settle();
        chk_b("str1_ready", bus.fetch_req_ready, 1'b1);
        chk_w("str1_addr", 32'(bus.im_addr), 32'h4);
        chk_rsp("str1_rsp", 16'h0000);
        step(); set_fetch(1'b1, 16'h0008); settle();
        chk_w("str2_addr", 32'(bus.im_addr), 32'h8);
        chk_rsp("str2_rsp", 16'h0004);
        step(); set_fetch(1'b0, 16'h0); settle();
        chk_b("str3_im_en", bus.im_en, 1'b0);
        chk_rsp("str3_rsp", 16'h0008);
        step(); settle();
        chk_b("str4_rsp", bus.fetch_rsp_valid, 1'b0);

        // Decode stall: two responses held, third request refused.
        step(); bus.fetch_rsp_ready = 1'b0; set_fetch(1'b1, 16'h0000); settle();
        chk_b("stl0_ready", bus.fetch_req_ready, 1'b1);
        step(); set_fetch(1'b1, 16'h0004); settle();
        chk_b("stl1_ready", bus.fetch_req_ready, 1'b1);
        chk_rsp("stl1_rsp", 16'h0000);
        step(); set_fetch(1'b1, 16'h0008); settle();
        chk_b("stl2_ready", bus.fetch_req_ready, 1'b0);
        chk_b("stl2_im_en", bus.im_en, 1'b0);
        step(); settle();
        chk_b("stl3_ready", bus.fetch_req_ready, 1'b0);
        chk_w("stl3_count", 32'(dut.fifo_count), 32'h2);
        chk_rsp("stl3_rsp", 16'h0000);
        step(); bus.fetch_rsp_ready = 1'b1; settle();
        chk_rsp("drn0_rsp", 16'h0000);
        chk_b("drn0_ready", bus.fetch_req_ready, 1'b1);
        chk_w("drn0_addr", 32'(bus.im_addr), 32'h8);
        step(); set_fetch(1'b0, 16'h0); settle();
        chk_rsp("drn1_rsp", 16'h0004);
        step(); settle();
        chk_rsp("drn2_rsp", 16'h0008);
        step(); settle();
        chk_b("drn3_rsp", bus.fetch_rsp_valid, 1'b0);

        // Flush with one buffered and one in-flight read, plus a new request.
        step(); bus.fetch_rsp_ready = 1'b0; set_fetch(1'b1, 16'h0008); settle();
        chk_b("fl0_ready", bus.fetch_req_ready, 1'b1);
        step(); set_fetch(1'b1, 16'h000C); settle();
        chk_b("fl1_ready", bus.fetch_req_ready, 1'b1);
        step(); bus.flush = 1'b1; bus.fetch_rsp_ready = 1'b1; set_fetch(1'b1, 16'h0040); settle();
        chk_b("fl2_rsp", bus.fetch_rsp_valid, 1'b0);
        chk_b("fl2_ready", bus.fetch_req_ready, 1'b1);
        chk_w("fl2_addr", 32'(bus.im_addr), 32'h40);
        step(); bus.flush = 1'b0; set_fetch(1'b0, 16'h0); settle();
        chk_rsp("fl3_rsp", 16'h0040);
        step(); settle();
        chk_b("fl4_rsp", bus.fetch_rsp_valid, 1'b0);

        // Starvation: aux read wins on the fifth contended cycle.
        step(); set_fetch(1'b1, 16'h0200); set_aux(1'b1, 1'b0, 16'h0300, 32'h0, 1'b0); settle();
        chk_b("stv0_aux_ready", bus.aux_req_ready, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step(); set_fetch(1'b1, 16'(16'h0200 + 4 * i)); settle();
            chk_b("stv_aux_ready", bus.aux_req_ready, 1'b0);
            chk_b("stv_fetch_ready", bus.fetch_req_ready, 1'b1);
        end
        step(); set_fetch(1'b1, 16'h0210); settle();
        chk_w("stv4_cnt", 32'(dut.starve_cnt), 32'h4);
        chk_b("stv4_aux_ready", bus.aux_req_ready, 1'b1);
        chk_b("stv4_fetch_ready", bus.fetch_req_ready, 1'b0);
        chk_w("stv4_addr", 32'(bus.im_addr), 32'h300);
        chk_rsp("stv4_rsp", 16'h020C);
        step(); set_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0); settle();
        chk_b("stv5_aux_rsp", bus.aux_rsp_valid, 1'b1);
        chk_w("stv5_aux_data", bus.aux_rsp_data, 32'hC0DE_0300);
        chk_w("stv5_cnt", 32'(dut.starve_cnt), 32'h0);
        chk_w("stv5_addr", 32'(bus.im_addr), 32'h210);
        chk_b("stv5_rsp", bus.fetch_rsp_valid, 1'b0);
        step(); set_fetch(1'b0, 16'h0); settle();
        chk_b("stv6_aux_rsp", bus.aux_rsp_valid, 1'b0);
        chk_rsp("stv6_rsp", 16'h0210);

        // Locked four-word aux write burst against continuous fetch.
        step(); set_fetch(1'b1, 16'h0400); set_aux(1'b1, 1'b1, 16'h0500, 32'h1111_1111, 1'b1); settle();
        chk_b("lk_wait_ready", bus.aux_req_ready, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step(); settle();
            chk_b("lk_wait_ready", bus.aux_req_ready, 1'b0);
        end
        for (int w = 0; w < 4; w++) begin
            step();
            set_aux(1'b1, 1'b1, 16'(16'h0500 + 4 * w), 32'(w + 1) * 32'h1111_1111, (w != 3));
            settle();
            chk_b("lk_aux_ready", bus.aux_req_ready, 1'b1);
            chk_b("lk_fetch_ready", bus.fetch_req_ready, 1'b0);
            chk_b("lk_im_we", bus.im_we, 1'b1);
            chk_w("lk_addr", 32'(bus.im_addr), 32'(16'h0500 + 4 * w));
            chk_w("lk_wdata", bus.im_wdata, 32'(w + 1) * 32'h1111_1111);
        end
        step(); set_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0); settle();
        chk_b("lk_rel_state", dut.state == ARB, 1'b1);
        chk_b("lk_rel_ready", bus.fetch_req_ready, 1'b1);
        chk_w("lk_rel_addr", 32'(bus.im_addr), 32'h400);
        chk_b("lk_rel_we", bus.im_we, 1'b0);
        chk_b("lk_rel_aux_rsp", bus.aux_rsp_valid, 1'b0);
        step(); set_fetch(1'b0, 16'h0); settle();
        chk_rsp("lk_rel_rsp", 16'h0400);
        step(); settle();

        // Reset with two responses buffered, FSM in LOCK and an aux read in flight.
        step(); bus.fetch_rsp_ready = 1'b0; set_fetch(1'b1, 16'h0600); settle();
        chk_b("mr0_ready", bus.fetch_req_ready, 1'b1);
        step(); set_fetch(1'b1, 16'h0604); settle();
        chk_b("mr1_ready", bus.fetch_req_ready, 1'b1);
        step(); set_fetch(1'b0, 16'h0); set_aux(1'b1, 1'b0, 16'h0680, 32'h0, 1'b1); settle();
        chk_b("mr2_aux_ready", bus.aux_req_ready, 1'b1);
        step(); set_fetch(1'b1, 16'h0608); settle();
        chk_b("mr3_state", dut.state == LOCK, 1'b1);
        chk_w("mr3_count", 32'(dut.fifo_count), 32'h2);
        chk_b("mr3_fetch_ready", bus.fetch_req_ready, 1'b0);
        chk_w("mr3_aux_data", bus.aux_rsp_data, 32'hC0DE_0680);
        step(); rst = 1'b1; settle();
        chk_b("mr4_fetch_ready", bus.fetch_req_ready, 1'b0);
        chk_b("mr4_aux_ready", bus.aux_req_ready, 1'b0);
        chk_b("mr4_im_en", bus.im_en, 1'b0);
        chk_b("mr4_rsp", bus.fetch_rsp_valid, 1'b0);
        chk_w("mr4_rsp_pc", 32'(bus.fetch_rsp_pc), 32'h0);
        chk_b("mr4_aux_rsp", bus.aux_rsp_valid, 1'b0);
        chk_w("mr4_aux_data", bus.aux_rsp_data, 32'h0);
        step(); rst = 1'b0; bus.fetch_rsp_ready = 1'b1;
        set_fetch(1'b0, 16'h0); set_aux(1'b0, 1'b0, 16'h0, 32'h0, 1'b0); settle();
        chk_b("mr5_state", dut.state == ARB, 1'b1);
        chk_w("mr5_count", 32'(dut.fifo_count), 32'h0);
        chk_b("mr5_rsp", bus.fetch_rsp_valid, 1'b0);
        chk_b("mr5_aux_rsp", bus.aux_rsp_valid, 1'b0);
        step(); set_fetch(1'b1, 16'h0700); settle();
        chk_b("mr6_ready", bus.fetch_req_ready, 1'b1);
        chk_w("mr6_addr", 32'(bus.im_addr), 32'h700);
        chk_b("mr6_rsp", bus.fetch_rsp_valid, 1'b0);
        step(); set_fetch(1'b0, 16'h0); settle();
        chk_rsp("mr7_rsp", 16'h0700);
        step(); settle();
        chk_b("mr8_rsp", bus.fetch_rsp_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
